// File: rtl/li_wta_tree.sv
// li_wta_tree: lateral-inhibition / winner-take-all stage with a pipelined tournament tree,
// threshold decision and per-neuron refractory suppression.
module li_wta_tree #(
   parameter int N      = 16,
   parameter int W      = 24,
   parameter int IDXW   = 4,
   parameter int L      = 4,
   parameter int REFRAC = 2,
   parameter int RW     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_li,
   input  logic [N*W-1:0]  potentials,
   input  logic [W-1:0]    th,
   input  logic            mode,
   output logic [N-1:0]    won_lost,
   output logic [IDXW-1:0] winner_idx,
   output logic [W-1:0]    winner_pot,
   output logic            valid_li,
   output logic            first_spike,
   output logic            busy
);
   localparam int P  = 1 << L;
   localparam int LW = $clog2(L + 1);
   typedef enum logic [1:0] {IDLE, CAPTURE, TREE, DECIDE} state_t;
   state_t state, state_nxt;
   logic [LW-1:0]   lvl;
   logic [W-1:0]    cap [N];
   logic [W-1:0]    val [P];
   logic [IDXW-1:0] idx [P];
   logic [RW-1:0]   cnt [N];
   logic [W-1:0]    th_r;
   logic            mode_r;
   logic [N-1:0]    above, wl;
   logic            cap_en, reduce, spike;
   assign busy   = (state != IDLE) || valid_li;
   assign cap_en = (state == IDLE) && start_li && !valid_li;
   assign reduce = (state == CAPTURE) || (state == TREE);
   always_comb begin
      state_nxt = state;
      above     = '0;
      unique case (state)
         IDLE:          state_nxt = cap_en ? CAPTURE : IDLE;
         CAPTURE, TREE: state_nxt = (lvl == LW'(L - 1)) ? DECIDE : TREE;
         DECIDE:        state_nxt = IDLE;
         default:       state_nxt = IDLE;
      endcase
      for (int i = 0; i < N; i++) above[i] = cap[i] > th_r;
      spike = val[0] > th_r;
      wl    = mode_r ? above : (spike ? (N'(1) << idx[0]) : '0);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         lvl         <= '0;
         valid_li    <= 1'b0;
         won_lost    <= '0;
         winner_idx  <= '0;
         winner_pot  <= '0;
         first_spike <= 1'b0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         state    <= state_nxt;
         valid_li <= state == DECIDE;
         if (cap_en) lvl <= '0;
         else if (reduce) lvl <= lvl + LW'(1);
         if (cap_en)
            for (int i = 0; i < N; i++) cnt[i] <= cnt[i] - RW'(cnt[i] != '0);
         if (state == DECIDE) begin
            winner_idx  <= idx[0];
            winner_pot  <= val[0];
            won_lost    <= wl;
            first_spike <= |wl;
            // A fresh load overrides the decrement made at capture
            for (int i = 0; i < N; i++)
               if (REFRAC != 0 && wl[i]) cnt[i] <= RW'(REFRAC);
         end
      end
   end
   // Datapath: leaves padded with zero-valued entries; ties keep the lower (even) slot
   always_ff @(posedge clk) begin
      if (cap_en) begin
         th_r   <= th;
         mode_r <= mode;
         for (int i = 0; i < P; i++) begin
            val[i] <= '0;
            idx[i] <= IDXW'(i);
         end
         for (int i = 0; i < N; i++) begin
            val[i] <= (cnt[i] == '0) ? potentials[W*i +: W] : '0;
            cap[i] <= (cnt[i] == '0) ? potentials[W*i +: W] : '0;
         end
      end else if (reduce) begin
         for (int j = 0; j < P / 2; j++) begin
            val[j] <= (val[2*j+1] > val[2*j]) ? val[2*j+1] : val[2*j];
            idx[j] <= (val[2*j+1] > val[2*j]) ? idx[2*j+1] : idx[2*j];
         end
      end
   end
endmodule

// File: tb/tb_li_wta_tree.sv
// tb_li_wta_tree: directed and random evaluations checked against a per-evaluation reference model.
module tb_li_wta_tree;
   localparam int N = 16, W = 24, IDXW = 4, L = 4, REFRAC = 2, RW = 2;
   logic clk = 0, rst = 0, start_li = 0, mode = 0;
   logic [N*W-1:0] potentials = '0;
   logic [W-1:0] th = '0;
   logic [N-1:0] won_lost;
   logic [IDXW-1:0] winner_idx;
   logic [W-1:0] winner_pot;
   logic valid_li, first_spike, busy;
   logic s_start = 0;
   logic [3*W-1:0] s_pot = '0;
   logic [2:0] s_won;
   logic [1:0] s_idx;
   logic [W-1:0] s_wpot;
   logic s_valid, s_fs, s_busy;
   int total = 0, bad = 0;
   int unsigned pv[N];
   int refr[N];
   logic [N-1:0] e_wl;
   int e_idx;
   int unsigned e_pot;

   always #5 clk = ~clk;

   li_wta_tree #(.N(N), .W(W), .IDXW(IDXW), .L(L), .REFRAC(REFRAC), .RW(RW)) dut (
      .clk(clk), .rst(rst), .start_li(start_li), .potentials(potentials), .th(th), .mode(mode),
      .won_lost(won_lost), .winner_idx(winner_idx), .winner_pot(winner_pot), .valid_li(valid_li),
      .first_spike(first_spike), .busy(busy));

   li_wta_tree #(.N(3), .W(W), .IDXW(2), .L(2), .REFRAC(REFRAC), .RW(RW)) dut3 (
      .clk(clk), .rst(rst), .start_li(s_start), .potentials(s_pot), .th('0), .mode(1'b0),
      .won_lost(s_won), .winner_idx(s_idx), .winner_pot(s_wpot), .valid_li(s_valid),
      .first_spike(s_fs), .busy(s_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int unsigned v);
      for (int i = 0; i < N; i++) pv[i] = v;
   endtask

   // Reference: max search over masked potentials, threshold, refractory bookkeeping
   task automatic model(input logic md, input logic [W-1:0] thr);
      logic [N-1:0] m;
      int unsigned v;
      for (int i = 0; i < N; i++) begin
         m[i] = refr[i] != 0;
         if (refr[i] > 0) refr[i]--;
      end
      e_idx = 0;
      e_pot = 0;
      for (int i = 0; i < N; i++) begin
         v = m[i] ? 0 : pv[i];
         if (v > e_pot) begin
            e_pot = v;
            e_idx = i;
         end
      end
      e_wl = '0;
      if (md) for (int i = 0; i < N; i++) e_wl[i] = !m[i] && pv[i] > thr;
      else if (e_pot > thr) e_wl[e_idx] = 1'b1;
      for (int i = 0; i < N; i++) if (e_wl[i] && REFRAC > 0) refr[i] = REFRAC;
   endtask

   task automatic drive(input logic md, input logic [W-1:0] thr);
      for (int i = 0; i < N; i++) potentials[W*i +: W] = W'(pv[i]);
      th = thr;
      mode = md;
   endtask

   task automatic run(input string tag, input logic md, input logic [W-1:0] thr);
      int lat;
      drive(md, thr);
      model(md, thr);
      start_li = 1;
      tick();
      start_li = 0;
      lat = 1;
      chk({tag, "_busy"}, busy, 1);
      while (valid_li !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, L + 2);
      chk({tag, "_wl"}, won_lost, e_wl);
      chk({tag, "_idx"}, winner_idx, e_idx);
      chk({tag, "_pot"}, winner_pot, e_pot);
      chk({tag, "_fs"}, first_spike, |e_wl);
      tick();
      chk({tag, "_vdrop"}, valid_li, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int lat, nv;
      for (int i = 0; i < N; i++) refr[i] = 0;
      repeat (3) tick();
      chk("rst_valid", valid_li, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wl", won_lost, 0);
      chk("rst_idx", winner_idx, 0);
      chk("rst_pot", winner_pot, 0);
      chk("rst_fs", first_spike, 0);
      rst = 1;
      tick();
      s_start = 1;
      tick();
      s_start = 0;
      lat = 1;
      while (s_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("n3_lat", lat, 4);
      chk("n3_idx", s_idx, 0);
      chk("n3_pot", s_wpot, 0);
      chk("n3_wl", s_won, 0);
      fill(10);
      pv[5] = 200;
      run("t1", 0, 90);
      chk("t1_wl_const", won_lost, 16'h0020);
      run("refr2", 0, 90);
      chk("refr2_pot", winner_pot, 10);
      run("refr3", 0, 90);
      chk("refr3_wl", won_lost, 0);
      run("refr4", 0, 90);
      chk("refr4_wl", won_lost, 16'h0020);
      drive(0, 90);
      start_li = 1;
      tick();
      start_li = 0;
      repeat (2) tick();
      rst = 0;
      tick();
      rst = 1;
      for (int i = 0; i < N; i++) refr[i] = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid_li, 0);
      chk("abort_wl", won_lost, 0);
      chk("abort_idx", winner_idx, 0);
      chk("abort_pot", winner_pot, 0);
      chk("abort_fs", first_spike, 0);
      nv = 0;
      repeat (8) begin
         if (valid_li) nv++;
         tick();
      end
      chk("abort_novalid", nv, 0);
      run("fresh", 0, 90);
      chk("fresh_wl", won_lost, 16'h0020);
      fill(10);
      pv[3] = 90;
      run("t2", 0, 90);
      chk("t2_idx", winner_idx, 3);
      fill(10);
      pv[2] = 150;
      pv[9] = 150;
      run("t3", 0, 90);
      chk("t3_idx", winner_idx, 2);
      fill(0);
      pv[1] = 100;
      pv[7] = 91;
      pv[12] = 90;
      run("t5", 1, 90);
      chk("t5_wl", won_lost, 16'h0082);
      fill(50);
      run("t5_follow", 1, 0);
      fill(10);
      pv[5] = 200;
      drive(0, 90);
      model(0, 90);
      start_li = 1;
      tick();
      start_li = 0;
      tick();
      start_li = 1;
      tick();
      start_li = 0;
      nv = 0;
      repeat (14) begin
         if (valid_li) nv++;
         tick();
      end
      chk("busy_ign_cnt", nv, 1);
      chk("busy_ign_wl", won_lost, e_wl);
      chk("busy_ign_idx", winner_idx, e_idx);
      for (int k = 0; k < 24; k++) begin
         logic [W-1:0] thr;
         for (int i = 0; i < N; i++) pv[i] = $urandom_range(0, 63);
         if (k == 7) fill(0);
         thr = (k == 5) ? '1 : W'($urandom_range(0, 70));
         run("rnd", 1'($urandom_range(0, 1)), thr);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/li_wta_tree.md
Name: li_wta_tree

Overview:
Parametrised lateral-inhibition / winner-take-all stage for the SNN output layer. It takes N packed membrane potentials and finds the strongest neuron with a pipelined tournament tree, one tree level per cycle. It then thresholds the result and returns a one-hot or multi-hot spike mask. Per-neuron refractory counters suppress a neuron that has just won for a programmable number of later evaluations.

Parameters:
N, 16, number of neurons; any value ≥ 2 (non-power-of-two allowed).
W, 24, potential width, unsigned.
IDXW, 4, index width; must satisfy 2^IDXW ≥ N.
L, 4, tree depth = ceil(log2 N); set consistently with N.
REFRAC, 2, evaluations a winner stays suppressed; 0 disables suppression.
RW, 2, refractory counter width; must hold REFRAC.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-low reset.
start_li  in  1  start request; accepted only when busy=0.
potentials  in  N*W  neuron i at bits [W*i+W-1 : W*i].
th  in  W  spike threshold; sampled with potentials.
mode  in  1  0 = WTA (single winner), 1 = all-above-threshold.
won_lost  out  N  spike mask, valid with valid_li.
winner_idx  out  IDXW  index of the maximum (masked) potential.
winner_pot  out  W  value of that potential.
valid_li  out  1  one-cycle result strobe.
first_spike  out  1  1 if any bit of won_lost is set; valid with valid_li.
busy  out  1  evaluation in progress.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0.
  - All refractory counters clear; FSM goes to IDLE.
  - Any evaluation in flight is discarded with no valid_li.
- FSM states: IDLE, CAPTURE, TREE (L cycles, level counter 0..L-1), DECIDE, then back to IDLE.
- IDLE: start_li=1 moves to CAPTURE at the next edge (edge T+1). start_li is ignored while busy=1.
- CAPTURE (edge T+1):
  - Register potentials, th and mode.
  - Neuron i is masked if its refractory count ≠ 0; a masked neuron's potential is forced to 0 and it is excluded from the mode-1 mask.
  - Each nonzero counter then decrements by 1. Counters change only here and in DECIDE, never per clock.
- TREE:
  - Leaves are padded to 2^L; pad entries have value 0 and index ≥ N.
  - Each level compares pairs with unsigned strict greater-than. Ties go to the lower index, so padding never beats a real neuron.
  - Each node carries an {index, value} pair; one level resolves per edge (edges T+2 .. T+1+L).
- DECIDE (edge T+2+L):
  - Register winner_idx and winner_pot; assert valid_li for exactly one cycle.
  - spike = winner_pot > th (strict).
  - mode 0: won_lost is one-hot at winner_idx if spike, else all zeros.
  - mode 1: won_lost[i] = (masked potential i > th).
  - first_spike = |won_lost.
  - If REFRAC > 0, every neuron whose won_lost bit is set loads its counter with REFRAC. Load takes priority over decrement.
- Latency: valid_li is high in the cycle after edge T+2+L, i.e. L+2 cycles after start is sampled (6 for N=16).
- busy is 1 from edge T+1 through the valid_li cycle. A start_li coinciding with the valid_li cycle is ignored; the earliest accepted restart is the next cycle.
- won_lost, first_spike, winner_idx and winner_pot hold their values until the next DECIDE or reset. They are meaningful only when valid_li=1.
- th=all-ones means no spike is possible. All potentials 0 gives winner_idx=0, winner_pot=0, no spike.

Test Plan:
1. N=16, th=90, mode 0, pot[5]=200, all others 10 → valid_li exactly 6 cycles after start; won_lost=16'h0020, winner_idx=5, winner_pot=200, first_spike=1.
2. Max is pot[3]=90 with th=90 → won_lost=0, first_spike=0, winner_idx=3, winner_pot=90 (threshold is strictly greater-than).
3. Tie: pot[2]=pot[9]=150 → winner_idx=2. Also build with N=3 (L=2), pot={0,0,0} → winner_idx=0, valid_li 4 cycles after start.
4. Refractory, REFRAC=2: repeat the vector from test 1 four times.
   - Evaluation 1: spike at index 5.
   - Evaluations 2 and 3: neuron 5 masked, so winner_pot=10, won_lost=0.
   - Evaluation 4: spike at index 5 again.
5. mode 1, th=90, pot[1]=100, pot[7]=91, pot[12]=90 → won_lost=16'h0082, winner_idx=1, first_spike=1; counters for neurons 1 and 7 both load 2.
6. Pulse start_li while busy=1 → ignored, only one valid_li. Drive rst=0 mid-TREE → next cycle busy=0, valid_li=0, outputs 0, counters cleared; a fresh start then completes normally.
